// File: rtl/tbec_pkg.sv
// Shared types and constants for the TBEC memory scrubber.
package tbec_pkg;

  localparam int TBEC_ADDR_W = 8;
  localparam int TBEC_DATA_W = 16;

  typedef enum logic [1:0] {
    TBEC_OK     = 2'b00,
    TBEC_CORR   = 2'b01,
    TBEC_UNCORR = 2'b10,
    TBEC_RSVD   = 2'b11
  } tbec_err_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CHK  = 3'd2,
    WB   = 3'd3,
    HOLD = 3'd4
  } tbec_state_e;

endpackage

// File: rtl/tbec_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module tbec_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tbec_scrubber.sv
// Background ECC scrubber sharing one memory port with a host.
// Define TBEC_SCRUB_AUTO_EN to add an idle timer that launches passes on its own.
module tbec_scrubber
  import tbec_pkg::*;
#(
  parameter int ADDR_W         = TBEC_ADDR_W,
  parameter int DATA_W         = TBEC_DATA_W,
  parameter int CNT_W          = 16,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic              tbec_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] dec_data,
  input  logic [1:0]        dec_err,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [7:0]        uncorr_cnt
);

  tbec_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              corr_inc, uncorr_inc, word_done, pass_go, timer_fire;

`ifdef TBEC_SCRUB_AUTO_EN
  localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  assign timer_fire = (state_q == IDLE) && (timer_q == TMR_W'(SCRUB_INTERVAL - 1));

  // Counts only while idle; any pass start (manual or timed) reloads it.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if ((state_q != IDLE) || pass_go) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge tbec_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_fire = 1'b0;
`endif

  assign pass_go = (state_q == IDLE) && (start || timer_fire);

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    word_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pass_go) begin
          state_d    = RD;
          addr_cnt_d = '0;
        end
      end
      RD:   state_d = CHK;
      CHK: begin
        data_d = dec_data;
        case (tbec_err_e'(dec_err))
          TBEC_OK:   word_done = 1'b1;
          TBEC_CORR: state_d = WB;
          default: begin
            uncorr_inc = 1'b1;
            word_done  = 1'b1;
          end
        endcase
      end
      WB: begin
        corr_inc  = 1'b1;
        word_done = 1'b1;
      end
      HOLD: begin
        if (!host_req) begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
    // The pass stops after the top address rather than wrapping back to 0.
    if (word_done) begin
      if (addr_cnt_q == '1) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        addr_cnt_d = addr_cnt_q + 1'b1;
        state_d    = host_req ? HOLD : RD;
      end
    end
  end

  always_ff @(posedge tbec_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // Host gating on rst_n keeps the port write-free while reset is held.
  always_comb begin
    host_gnt  = host_req && ((state_q == IDLE) || (state_q == HOLD));
    mem_addr  = addr_cnt_q;
    mem_we    = 1'b0;
    mem_wdata = data_q;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_we    = host_we && rst_n;
      mem_wdata = host_wdata;
    end else if (state_q == WB) begin
      mem_we = 1'b1;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  tbec_sat_cnt #(.W(CNT_W)) u_corr_cnt (
    .clk   (tbec_clk),
    .rst_n (rst_n),
    .inc   (corr_inc),
    .count (corr_cnt)
  );

  tbec_sat_cnt #(.W(8)) u_uncorr_cnt (
    .clk   (tbec_clk),
    .rst_n (rst_n),
    .inc   (uncorr_inc),
    .count (uncorr_cnt)
  );

endmodule

// File: tb/tb_tbec_scrubber.sv
// Self-checking bench for tbec_scrubber: memory/decoder environment, table vectors,
// directed corner sequences and randomized fault passes against a pass-level model.
module tb_tbec_scrubber;

  logic        tbec_clk   = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start      = 1'b0;
  logic        host_req   = 1'b0;
  logic        host_we    = 1'b0;
  logic [7:0]  host_addr  = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] dec_data = '0;
  logic [1:0]  dec_err  = '0;
  logic        busy, done;
  logic [15:0] corr_cnt;
  logic [7:0]  uncorr_cnt;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem_true [256];
  logic [1:0]  mem_flt  [256];
  logic [23:0] wlog [$];
  logic [23:0] exp_wlog [$];
  int exp_corr   = 0;
  int exp_uncorr = 0;
  int busy_cyc, done_cnt;

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        exp_gnt;
    logic        exp_we;
  } vec_t;

  vec_t vecs [4];

  always #5 tbec_clk = ~tbec_clk;

  tbec_scrubber dut (
    .tbec_clk   (tbec_clk),
    .rst_n      (rst_n),
    .start      (start),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .dec_data   (dec_data),
    .dec_err    (dec_err),
    .busy       (busy),
    .done       (done),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  // Memory + decoder: a write re-encodes the word (fault cleared); reads have one cycle latency.
  always @(posedge tbec_clk) begin
    if (mem_we) begin
      mem_true[mem_addr] = mem_wdata;
      mem_flt[mem_addr]  = 2'b00;
    end else begin
      dec_err  <= mem_flt[mem_addr];
      dec_data <= mem_flt[mem_addr][1] ? ~mem_true[mem_addr] : mem_true[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge tbec_clk);
    host_req   = v.req;
    host_we    = v.we;
    host_addr  = v.addr;
    host_wdata = v.wdata;
    #1;
  endtask

  // Pass-level expectation: every correctable word is rewritten once with its true data.
  task automatic modelPass(output int n_corr);
    exp_wlog.delete();
    n_corr = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem_flt[a] == 2'b01) begin
        exp_wlog.push_back({8'(a), mem_true[a]});
        n_corr++;
        exp_corr = (exp_corr < 65535) ? exp_corr + 1 : 65535;
      end else if (mem_flt[a][1]) begin
        exp_uncorr = (exp_uncorr < 255) ? exp_uncorr + 1 : 255;
      end
    end
  endtask

  task automatic waitDone(input int bound);
    bit seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge tbec_clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic runPass(input int restart_at);
    int n_corr;
    bit seen = 1'b0;
    modelPass(n_corr);
    wlog.delete();
    busy_cyc = 0;
    done_cnt = 0;
    @(negedge tbec_clk);
    start = 1'b1;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge tbec_clk);
      start = (c == restart_at);
      if (c == 0) checkOutput("pass_first_addr", 32'(mem_addr), 32'd0);
      if (busy) busy_cyc++;
      if (mem_we && !host_gnt) wlog.push_back({mem_addr, mem_wdata});
      if (done) begin
        done_cnt++;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    checkOutput("pass_done_seen", 32'(seen), 32'd1);
    repeat (3) begin
      @(negedge tbec_clk);
      if (done) done_cnt++;
    end
    checkOutput("busy_cycles", 32'(busy_cyc), 32'(512 + n_corr));
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
    checkOutput("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_uncorr));
    checkOutput("wb_count", 32'(wlog.size()), 32'(exp_wlog.size()));
    for (int i = 0; i < wlog.size() && i < exp_wlog.size(); i++) begin
      checkOutput($sformatf("wb_entry%0d", i), 32'(wlog[i]), 32'(exp_wlog[i]));
    end
  endtask

  initial begin
    int waits;
    bit wb_seen;
    bit found;
    logic [15:0] v5;
    logic [15:0] v10;
    int r;

    for (int a = 0; a < 256; a++) begin
      mem_true[a] = 16'($urandom);
      mem_flt[a]  = 2'b00;
    end
    vecs[0] = '{1'b1, 1'b0, 8'h12, 16'h1234, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h22, 16'hA5A5, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 16'h0F0F, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 16'h7E7E, 1'b1, 1'b1};

    // Reset: host still sees grants but no write reaches memory.
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_addr = 8'h55;
    repeat (2) @(negedge tbec_clk);
    checkOutput("rst_host_gnt", 32'(host_gnt), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_corr", 32'(corr_cnt), 32'd0);
    checkOutput("rst_uncorr", 32'(uncorr_cnt), 32'd0);
    host_req = 1'b0;
    host_we  = 1'b0;
    @(negedge tbec_clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("idle_gnt%0d", i), 32'(host_gnt), 32'(vecs[i].exp_gnt));
      checkOutput($sformatf("idle_we%0d", i), 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_gnt) begin
        checkOutput($sformatf("idle_addr%0d", i), 32'(mem_addr), 32'(vecs[i].addr));
        checkOutput($sformatf("idle_wdata%0d", i), 32'(mem_wdata), 32'(vecs[i].wdata));
      end
    end
    @(negedge tbec_clk);
    host_req = 1'b0;
    host_we  = 1'b0;

    // Clean pass, with a second start pulse mid-pass that must be ignored.
    runPass(100);

    // Single correctable fault at 0x05, then a host reread.
    mem_flt[8'h05] = 2'b01;
    v5 = mem_true[8'h05];
    runPass(-1);
    @(negedge tbec_clk);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h05;
    @(negedge tbec_clk);
    checkOutput("reread_err", 32'(dec_err), 32'd0);
    checkOutput("reread_data", 32'(dec_data), 32'(v5));
    host_req = 1'b0;

    // Uncorrectable fault at 0x80: counted, never written.
    mem_flt[8'h80] = 2'b10;
    runPass(-1);
    checkOutput("uncorr_not_written", 32'(mem_flt[8'h80]), 32'd2);

    // Host request arrives during CHK of 0x10 which also needs a writeback.
    for (int a = 0; a < 256; a++) mem_flt[a] = 2'b00;
    mem_flt[8'h10] = 2'b01;
    v10 = mem_true[8'h10];
    modelPass(r);
    @(negedge tbec_clk);
    start = 1'b1;
    @(negedge tbec_clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (busy && mem_addr == 8'h10 && !mem_we) found = 1'b1;
      else @(negedge tbec_clk);
    end
    checkOutput("reach_rd_0x10", 32'(found), 32'd1);
    @(negedge tbec_clk);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h30;
    host_wdata = 16'hBEEF;
    waits   = 0;
    wb_seen = 1'b0;
    while (!host_gnt && waits < 5) begin
      @(negedge tbec_clk);
      waits++;
      if (mem_we && !host_gnt && mem_addr == 8'h10) wb_seen = 1'b1;
    end
    checkOutput("host_gnt_wait", 32'(waits), 32'd2);
    checkOutput("wb_before_hold", 32'(wb_seen), 32'd1);
    checkOutput("hold_mem_we", 32'(mem_we), 32'd1);
    checkOutput("hold_mem_addr", 32'(mem_addr), 32'h30);
    checkOutput("hold_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    @(negedge tbec_clk);
    host_req = 1'b0;
    host_we  = 1'b0;
    @(negedge tbec_clk);
    checkOutput("resume_addr", 32'(mem_addr), 32'h11);
    checkOutput("resume_busy", 32'(busy), 32'd1);
    waitDone(1000);
    checkOutput("host_write_landed", 32'(mem_true[8'h30]), 32'hBEEF);
    checkOutput("wb_0x10_data", 32'(mem_true[8'h10]), 32'(v10));
    checkOutput("wb_0x10_fixed", 32'(mem_flt[8'h10]), 32'd0);
    checkOutput("host_pass_corr", 32'(corr_cnt), 32'(exp_corr));

    // Randomized fault maps against the pass model.
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < 256; a++) begin
        r = int'($urandom_range(0, 15));
        mem_flt[a] = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
        if (r == 3) mem_true[a] = 16'($urandom);
      end
      runPass(-1);
    end

    // Every word uncorrectable drives the 8-bit counter into saturation.
    for (int a = 0; a < 256; a++) mem_flt[a] = 2'b10;
    runPass(-1);
    checkOutput("uncorr_saturated", 32'(uncorr_cnt), 32'd255);

    // Reset asserted during a writeback aborts it without writing.
    for (int a = 0; a < 256; a++) mem_flt[a] = 2'b00;
    mem_flt[8'h40] = 2'b01;
    @(negedge tbec_clk);
    start = 1'b1;
    @(negedge tbec_clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (mem_we && !host_gnt) found = 1'b1;
      else @(negedge tbec_clk);
    end
    checkOutput("reach_wb", 32'(found), 32'd1);
    checkOutput("wb_addr_0x40", 32'(mem_addr), 32'h40);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_corr", 32'(corr_cnt), 32'd0);
    checkOutput("abort_uncorr", 32'(uncorr_cnt), 32'd0);
    exp_corr   = 0;
    exp_uncorr = 0;
    repeat (2) @(negedge tbec_clk);
    checkOutput("abort_no_write", 32'(mem_flt[8'h40]), 32'd1);
    rst_n = 1'b1;
    runPass(-1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
